// File: rtl/usrt_rx_if.sv
// Pins between a synchronous serial peer and the usrt_rx receiver.
// The peer drives the bit clock and data; the receiver returns the word, its strobes and a state view.
interface usrt_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 i_Bclk;
  logic                 i_Rx_Serial;
  logic [DATA_BITS-1:0] o_Rx_Byte;
  logic                 o_Rx_DV;
  logic                 o_Frame_Err;
  logic                 o_Parity_Err;
  logic                 o_Busy;
  logic [2:0]           dbg_state;

  // There is no backpressure. o_Rx_DV, o_Frame_Err and o_Parity_Err are one-cycle strobes.
  // A consumer must take o_Rx_Byte (held until the next good frame) in the cycle o_Rx_DV is high.
  modport master (
    output i_Bclk, i_Rx_Serial,
    input  o_Rx_Byte, o_Rx_DV, o_Frame_Err, o_Parity_Err, o_Busy, dbg_state
  );

  modport slave (
    input  i_Bclk, i_Rx_Serial,
    output o_Rx_Byte, o_Rx_DV, o_Frame_Err, o_Parity_Err, o_Busy, dbg_state
  );
endinterface

// File: rtl/usrt_rx.sv
// Synchronous serial receiver: samples i_Rx_Serial on each rising edge of the peer bit clock.
// It assembles start / LSB-first data / [parity] / stop frames. Define USRT_RX_PARITY_EN to add the parity bit.
module usrt_rx #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic      i_Pclk,
  input  logic      i_Rst_n,
  usrt_rx_if.slave  rx_if
);

  localparam int CNT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

  if ((DATA_BITS < 5) || (DATA_BITS > 9) || (PARITY_ODD < 0) || (PARITY_ODD > 1)) begin : g_bad_cfg
    $error("usrt_rx: DATA_BITS must be 5..9 and PARITY_ODD 0 or 1");
  end

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DATA     = 3'd1,
`ifdef USRT_RX_PARITY_EN
    S_PARITY   = 3'd2,
`endif
    S_STOP     = 3'd3,
    S_BRK_WAIT = 3'd4
  } state_e;

  // The synchronisers idle at 1, so a Bclk held high through reset never looks like an edge.
  logic bclk_s1_q, bclk_s1_d;
  logic bclk_s2_q, bclk_s2_d;
  logic bclk_prev_q, bclk_prev_d;
  logic rx_s1_q, rx_s1_d;
  logic rx_s2_q, rx_s2_d;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_byte_q, rx_byte_d;
  logic                 rx_dv_q, rx_dv_d;
  logic                 frame_err_q, frame_err_d;
  logic                 busy_q, busy_d;
`ifdef USRT_RX_PARITY_EN
  localparam logic ODD_BIT = 1'(PARITY_ODD);
  logic                 par_bit_q, par_bit_d;
  logic                 parity_err_q, parity_err_d;
`endif

  logic samp;
  logic rx_bit;

  always_comb begin
    bclk_s1_d   = rx_if.i_Bclk;
    bclk_s2_d   = bclk_s1_q;
    bclk_prev_d = bclk_s2_q;
    rx_s1_d     = rx_if.i_Rx_Serial;
    rx_s2_d     = rx_s1_q;
  end

  assign samp   = bclk_s2_q & ~bclk_prev_q;
  assign rx_bit = rx_s2_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    rx_byte_d   = rx_byte_q;
    rx_dv_d     = 1'b0;
    frame_err_d = 1'b0;
`ifdef USRT_RX_PARITY_EN
    par_bit_d    = par_bit_q;
    parity_err_d = 1'b0;
`endif
    if (samp) begin
      case (state_q)
        S_IDLE: begin
          if (!rx_bit) begin
            state_d = S_DATA;
            cnt_d   = '0;
          end
        end
        S_DATA: begin
          // Shifting in from the MSB leaves the first data bit at the LSB after DATA_BITS samples.
          shift_d = {rx_bit, shift_q[DATA_BITS-1:1]};
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BIT) begin
`ifdef USRT_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
`ifdef USRT_RX_PARITY_EN
        S_PARITY: begin
          par_bit_d = rx_bit;
          state_d   = S_STOP;
        end
`endif
        S_STOP: begin
          if (rx_bit) begin
            rx_byte_d = shift_q;
            rx_dv_d   = 1'b1;
`ifdef USRT_RX_PARITY_EN
            parity_err_d = par_bit_q ^ (^shift_q) ^ ODD_BIT;
`endif
            state_d   = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BRK_WAIT;
          end
        end
        S_BRK_WAIT: begin
          // A held-low line must return high before the next start bit counts.
          if (rx_bit) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_Pclk) begin
    if (!i_Rst_n) begin
      bclk_s1_q   <= 1'b1;
      bclk_s2_q   <= 1'b1;
      bclk_prev_q <= 1'b1;
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      rx_byte_q   <= '0;
      rx_dv_q     <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      bclk_s1_q   <= bclk_s1_d;
      bclk_s2_q   <= bclk_s2_d;
      bclk_prev_q <= bclk_prev_d;
      rx_s1_q     <= rx_s1_d;
      rx_s2_q     <= rx_s2_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      rx_byte_q   <= rx_byte_d;
      rx_dv_q     <= rx_dv_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

`ifdef USRT_RX_PARITY_EN
  always_ff @(posedge i_Pclk) begin
    if (!i_Rst_n) begin
      par_bit_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_bit_q    <= par_bit_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign rx_if.o_Parity_Err = parity_err_q;
`else
  assign rx_if.o_Parity_Err = 1'b0;
`endif

  assign rx_if.o_Rx_Byte   = rx_byte_q;
  assign rx_if.o_Rx_DV     = rx_dv_q;
  assign rx_if.o_Frame_Err = frame_err_q;
  assign rx_if.o_Busy      = busy_q;
  assign rx_if.dbg_state   = state_q;

endmodule

// File: tb/tb_usrt_rx.sv
// Bench for usrt_rx: a table of frames plus hand-written break, reset, parity and idle sequences.
// A negedge monitor pops the expected {parity_err, byte} queue on every o_Rx_DV.
module tb_usrt_rx;
  localparam int DATA_BITS  = 8;
  localparam int PARITY_ODD = 0;
  localparam int HALF       = 4;
`ifdef USRT_RX_PARITY_EN
  localparam int FRAME_BITS = DATA_BITS + 3;
`else
  localparam int FRAME_BITS = DATA_BITS + 2;
`endif
  localparam int W = DATA_BITS + 1;

  logic i_Pclk  = 1'b0;
  logic i_Rst_n = 1'b0;

  usrt_rx_if #(.DATA_BITS(DATA_BITS)) rx_if ();

  usrt_rx #(.DATA_BITS(DATA_BITS), .PARITY_ODD(PARITY_ODD)) dut (
    .i_Pclk  (i_Pclk),
    .i_Rst_n (i_Rst_n),
    .rx_if   (rx_if)
  );

  always #5 i_Pclk = ~i_Pclk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];
  int exp_fe = 0;
  int fe_cnt = 0;
  int cyc    = 0;
  int dv_cyc[$];
  bit busy_seen = 0;
  logic prev_dv = 1'b0;
  logic [W-1:0] mon_e;
  logic [DATA_BITS-1:0] last_good = '0;

  typedef struct {
    logic [DATA_BITS-1:0] data;
    logic                 stop;
    logic                 par_flip;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(posedge i_Pclk) cyc <= cyc + 1;

  always @(negedge i_Pclk) begin
    if (i_Rst_n) begin
      if (rx_if.o_Busy) busy_seen = 1;
      if (rx_if.o_Frame_Err) fe_cnt++;
      if (rx_if.o_Rx_DV) begin
        dv_cyc.push_back(cyc);
        check("dv_one_cycle", {31'd0, prev_dv}, 32'd0);
        check("dv_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("rx_byte", 32'(rx_if.o_Rx_Byte), 32'(mon_e[DATA_BITS-1:0]));
          check("parity_err", {31'd0, rx_if.o_Parity_Err}, {31'd0, mon_e[DATA_BITS]});
        end
      end
      if (rx_if.o_Parity_Err) check("parity_err_needs_dv", {31'd0, rx_if.o_Rx_DV}, 32'd1);
    end
    prev_dv = rx_if.o_Rx_DV;
  end

  // Called at posedge+1; drives one bit: low phase of HALF cycles, then high phase of HALF cycles.
  task automatic send_bit(input logic b, input bit chk_lat);
    rx_if.i_Rx_Serial = b;
    rx_if.i_Bclk      = 1'b0;
    repeat (HALF) begin @(posedge i_Pclk); #1; end
    rx_if.i_Bclk = 1'b1;
    for (int k = 1; k <= HALF; k++) begin
      @(posedge i_Pclk); #1;
      if (chk_lat) begin
        if (k == 2) check("dv_latency_early", {31'd0, rx_if.o_Rx_DV}, 32'd0);
        if (k == 3) check("dv_latency_on",    {31'd0, rx_if.o_Rx_DV}, 32'd1);
        if (k == 4) check("dv_latency_after", {31'd0, rx_if.o_Rx_DV}, 32'd0);
      end
    end
  endtask

  task automatic send_frame(input logic [DATA_BITS-1:0] data, input logic stop,
                            input logic par_flip, input bit chk_lat);
    logic pe;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < DATA_BITS; i++) send_bit(data[i], 1'b0);
`ifdef USRT_RX_PARITY_EN
    send_bit((^data) ^ 1'(PARITY_ODD) ^ par_flip, 1'b0);
    pe = par_flip;
`else
    pe = 1'b0;
`endif
    if (stop) begin
      exp_q.push_back({pe, data});
      last_good = data;
    end else begin
      exp_fe++;
    end
    send_bit(stop, chk_lat);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n_dv;
    rx_if.i_Bclk      = 1'b1;
    rx_if.i_Rx_Serial = 1'b1;
    i_Rst_n           = 1'b0;
    repeat (3) begin @(posedge i_Pclk); #1; end
    check("rst_byte",  32'(rx_if.o_Rx_Byte), 32'd0);
    check("rst_dv",    {31'd0, rx_if.o_Rx_DV}, 32'd0);
    check("rst_fe",    {31'd0, rx_if.o_Frame_Err}, 32'd0);
    check("rst_pe",    {31'd0, rx_if.o_Parity_Err}, 32'd0);
    check("rst_busy",  {31'd0, rx_if.o_Busy}, 32'd0);
    i_Rst_n = 1'b1;
    repeat (4) begin @(posedge i_Pclk); #1; end
    check("no_samp_after_rst", {31'd0, rx_if.o_Busy}, 32'd0);

    // Single frame with exact strobe timing around the stop sample.
    send_frame(8'h4A, 1'b1, 1'b0, 1'b1);
    check("t1_byte", 32'(rx_if.o_Rx_Byte), 32'h4A);
    check("t1_fe",   32'(fe_cnt), 32'(exp_fe));
    check("t1_busy", {31'd0, rx_if.o_Busy}, 32'd0);

    // Back-to-back frames: strobes one full frame apart.
    dv_cyc.delete();
    send_frame(8'h00, 1'b1, 1'b0, 1'b0);
    check("t2_byte0", 32'(rx_if.o_Rx_Byte), 32'h00);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
    check("t2_byte1", 32'(rx_if.o_Rx_Byte), 32'hFF);
    check("t2_dv_count", 32'(dv_cyc.size()), 32'd2);
    if (dv_cyc.size() == 2)
      check("t2_dv_spacing", 32'(dv_cyc[1] - dv_cyc[0]), 32'(FRAME_BITS * 2 * HALF));

    // Table of frames, including one framing error and random payloads.
    vecs[0] = '{8'h4A, 1'b1, 1'b0};
    vecs[1] = '{8'h01, 1'b1, 1'b0};
    vecs[2] = '{8'h80, 1'b1, 1'b1};
    vecs[3] = '{8'hC3, 1'b0, 1'b0};
    vecs[4] = '{8'h5A, 1'b1, 1'b0};
    vecs[5] = '{8'hFE, 1'b0, 1'b1};
    for (int i = 6; i < 10; i++) begin
      vecs[i].data     = DATA_BITS'($urandom_range(0, (1 << DATA_BITS) - 1));
      vecs[i].stop     = 1'b1;
      vecs[i].par_flip = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < 10; i++) begin
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].par_flip, 1'b0);
      if (!vecs[i].stop) send_bit(1'b1, 1'b0);
      check("tbl_byte_held", 32'(rx_if.o_Rx_Byte), 32'(last_good));
      check("tbl_fe_count",  32'(fe_cnt), 32'(exp_fe));
      check("tbl_busy_idle", {31'd0, rx_if.o_Busy}, 32'd0);
    end

    // Break: bad stop, line held low, then recovery and a clean frame.
    n_dv = dv_cyc.size();
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      send_bit(1'b0, 1'b0);
      check("t3_busy_in_break", {31'd0, rx_if.o_Busy}, 32'd1);
    end
    check("t3_fe_once", 32'(fe_cnt), 32'(exp_fe));
    check("t3_no_dv",   32'(dv_cyc.size()), 32'(n_dv));
    check("t3_byte_kept", 32'(rx_if.o_Rx_Byte), 32'(last_good));
    send_bit(1'b1, 1'b0);
    check("t3_idle_after_break", {31'd0, rx_if.o_Busy}, 32'd0);
    send_frame(8'h33, 1'b1, 1'b0, 1'b0);
    check("t3_byte_33", 32'(rx_if.o_Rx_Byte), 32'h33);

    // Reset mid-frame after the 4th data bit, with Bclk high and data low throughout.
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    check("t4_busy_mid", {31'd0, rx_if.o_Busy}, 32'd1);
    rx_if.i_Rx_Serial = 1'b0;
    i_Rst_n = 1'b0;
    repeat (2) begin @(posedge i_Pclk); #1; end
    i_Rst_n = 1'b1;
    last_good = '0;
    check("t4_rst_byte", 32'(rx_if.o_Rx_Byte), 32'd0);
    check("t4_rst_busy", {31'd0, rx_if.o_Busy}, 32'd0);
    repeat (6) begin @(posedge i_Pclk); #1; end
    check("t4_no_spurious", {31'd0, rx_if.o_Busy}, 32'd0);
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    check("t4_byte_a5", 32'(rx_if.o_Rx_Byte), 32'hA5);

`ifdef USRT_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0, 1'b0);
    check("t5_good_par_byte", 32'(rx_if.o_Rx_Byte), 32'h07);
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    check("t5_bad_par_byte", 32'(rx_if.o_Rx_Byte), 32'h07);
`endif

    // Idle line with a free-running bit clock.
    n_dv = dv_cyc.size();
    busy_seen = 0;
    for (int i = 0; i < 50; i++) send_bit(1'b1, 1'b0);
    check("t6_busy_never", {31'd0, busy_seen}, 32'd0);
    check("t6_no_dv", 32'(dv_cyc.size()), 32'(n_dv));
    check("t6_no_fe", 32'(fe_cnt), 32'(exp_fe));

    check("all_frames_seen", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
